id_ex_issue_stage: RTL and testbench

//  ID/EX pipeline stage directly upstream of the EX-stage ALU: registers decoded operands, ALU control

---
 rtl/alu_pkg.sv | 21 ++
 rtl/id_ex_issue_stage_fwd_sel.sv | 45 ++++
 rtl/id_ex_issue_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_issue_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the EX stage and its issue logic.
//
// Contents:
//   ALU_* control codes presented on alu_ctrl_o
//   issue_state_t  occupancy state of the ID/EX issue stage
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1011;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        MUL_WAIT = 2'd1,
        FULL     = 2'd2
    } issue_state_t;

endpackage

// File: rtl/id_ex_issue_stage_fwd_sel.sv
// fwd_sel: forwarding select for one ALU operand.
// EX/MEM wins over MEM/WB; register index 0 never matches because a
// producer is only considered when its destination index is non-zero.
//
// Ports:
//   rs            operand's source register index
//   operand       captured operand value
//   exmem_*       EX/MEM forwarding source (rd, write enable, data)
//   memwb_*       MEM/WB forwarding source (rd, write enable, data)
//   data          selected operand value
//   hit           a forwarding source matched
module fwd_sel
    import alu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [31:0]       operand,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_we,
    input  logic [31:0]       exmem_data,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_we,
    input  logic [31:0]       memwb_data,
    output logic [31:0]       data,
    output logic              hit
);

    logic hit_exmem;
    logic hit_memwb;

    always_comb begin
        hit_exmem = exmem_we && (exmem_rd != '0) && (exmem_rd == rs);
        hit_memwb = memwb_we && (memwb_rd != '0) && (memwb_rd == rs);
        hit       = hit_exmem || hit_memwb;
        if (hit_exmem) begin
            data = exmem_data;
        end else if (hit_memwb) begin
            data = memwb_data;
        end else begin
            data = operand;
        end
    end

endmodule

// File: rtl/id_ex_issue_stage.sv
// id_ex_issue_stage: ID/EX register in front of the EX-stage ALU.
// Captures a decoded instruction, presents it to the ALU and raises
// out_valid_o when the ALU result is ready. A MUL is held for MUL_CYCLES
// cycles so the ALU's combinational multiplier is a multicycle path.
//
// Optional feature macro: FWD_EN (EX/MEM and MEM/WB operand forwarding).
// Without it the forwarding ports are ignored.
//
// Parameters: MUL_CYCLES (1..15), REG_AW (register index width)
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   in_valid_i / in_ready_o            decode-side handshake
//   src1_i, src2_i, ctrl_i, rs_i, rt_i, rd_i, regwrite_i   decoded instruction
//   exmem_rd_i/we_i/data_i, memwb_rd_i/we_i/data_i          forwarding sources
//   alu_src1_o, alu_src2_o, alu_ctrl_o ALU inputs
//   rd_o, regwrite_o                   destination tag
//   out_valid_o / out_ready_i          EX/MEM-side handshake
module id_ex_issue_stage
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int REG_AW     = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       src1_i,
    input  logic [31:0]       src2_i,
    input  logic [3:0]        ctrl_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_we_i,
    input  logic [31:0]       exmem_data_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_we_i,
    input  logic [31:0]       memwb_data_i,
    output logic [31:0]       alu_src1_o,
    output logic [31:0]       alu_src2_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              regwrite_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

`ifdef FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    issue_state_t      state;
    logic [3:0]        cnt;
    logic [31:0]       src1_q;
    logic [31:0]       src2_q;
    logic [3:0]        ctrl_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;
    logic              regwrite_q;
    logic              valid_q;

    logic              capture;
    logic              active;
    logic [31:0]       fwd1_data;
    logic [31:0]       fwd2_data;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic              fwd1_on;
    logic              fwd2_on;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_src1 (
        .rs         (rs_q),
        .operand    (src1_q),
        .exmem_rd   (exmem_rd_i),
        .exmem_we   (exmem_we_i),
        .exmem_data (exmem_data_i),
        .memwb_rd   (memwb_rd_i),
        .memwb_we   (memwb_we_i),
        .memwb_data (memwb_data_i),
        .data       (fwd1_data),
        .hit        (fwd1_hit)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_src2 (
        .rs         (rt_q),
        .operand    (src2_q),
        .exmem_rd   (exmem_rd_i),
        .exmem_we   (exmem_we_i),
        .exmem_data (exmem_data_i),
        .memwb_rd   (memwb_rd_i),
        .memwb_we   (memwb_we_i),
        .memwb_data (memwb_data_i),
        .data       (fwd2_data),
        .hit        (fwd2_hit)
    );

    assign in_ready_o = !flush_i && ((state == EMPTY) || ((state == FULL) && out_ready_i));
    assign capture    = in_valid_i && in_ready_o;

    // Forwarding only applies while an instruction occupies the stage; in
    // EMPTY the outputs simply hold whatever was last shown.
    assign active  = (state != EMPTY);
    assign fwd1_on = FWD_ON && active && fwd1_hit;
    assign fwd2_on = FWD_ON && active && fwd2_hit;

    assign alu_src1_o  = fwd1_on ? fwd1_data : src1_q;
    assign alu_src2_o  = fwd2_on ? fwd2_data : src2_q;
    assign alu_ctrl_o  = ctrl_q;
    assign rd_o        = rd_q;
    assign regwrite_o  = regwrite_q;
    assign out_valid_o = valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= EMPTY;
            cnt        <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            ctrl_q     <= ALU_AND;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            // A forwarded value is written back so it survives the
            // producer leaving EX/MEM or MEM/WB; a new capture wins.
            if (fwd1_on && !capture) src1_q <= fwd1_data;
            if (fwd2_on && !capture) src2_q <= fwd2_data;

            if (flush_i) begin
                state   <= EMPTY;
                cnt     <= '0;
                valid_q <= 1'b0;
            end else if (capture) begin
                src1_q     <= src1_i;
                src2_q     <= src2_i;
                ctrl_q     <= ctrl_i;
                rs_q       <= rs_i;
                rt_q       <= rt_i;
                rd_q       <= rd_i;
                regwrite_q <= regwrite_i;
                if ((ctrl_i == ALU_MUL) && (MUL_CYCLES > 1)) begin
                    state   <= MUL_WAIT;
                    cnt     <= MUL_LOAD;
                    valid_q <= 1'b0;
                end else begin
                    state   <= FULL;
                    cnt     <= '0;
                    valid_q <= 1'b1;
                end
            end else begin
                case (state)
                    MUL_WAIT: begin
                        if (cnt == 4'd1) begin
                            state   <= FULL;
                            cnt     <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    FULL: begin
                        if (out_ready_i) begin
                            state   <= EMPTY;
                            valid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_id_ex_issue_stage.sv
module tb_id_ex_issue_stage;

    localparam int MC = 3;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_MUL = 4'b1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1, src2;
    logic [3:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic        regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd_out;
    logic        regwrite_out;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: one held instruction plus the number of cycles still
    // to wait before its result is valid.
    bit          m_have;
    int          m_wait;
    logic [31:0] m_src1, m_src2;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_we;

    id_ex_issue_stage #(.MUL_CYCLES(MC), .REG_AW(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .src1_i       (src1),
        .src2_i       (src2),
        .ctrl_i       (ctrl),
        .rs_i         (rs),
        .rt_i         (rt),
        .rd_i         (rd),
        .regwrite_i   (regwrite),
        .exmem_rd_i   (exmem_rd),
        .exmem_we_i   (exmem_we),
        .exmem_data_i (exmem_data),
        .memwb_rd_i   (memwb_rd),
        .memwb_we_i   (memwb_we),
        .memwb_data_i (memwb_data),
        .alu_src1_o   (alu_src1),
        .alu_src2_o   (alu_src2),
        .alu_ctrl_o   (alu_ctrl),
        .rd_o         (rd_out),
        .regwrite_o   (regwrite_out),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] held);
`ifdef FWD_EN
        if (exmem_we && exmem_rd != 0 && exmem_rd == idx) return exmem_data;
        if (memwb_we && memwb_rd != 0 && memwb_rd == idx) return memwb_data;
`endif
        return held;
    endfunction

    task automatic model_reset();
        m_have = 0; m_wait = 0;
        m_src1 = 0; m_src2 = 0; m_ctrl = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_we = 0;
    endtask

    task automatic set_in(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic ordy, input logic fl);
        in_valid = v; ctrl = c; src1 = a; src2 = b; out_ready = ordy; flush = fl;
        rs = 5'd1; rt = 5'd2; rd = 5'd4; regwrite = 1'b1;
    endtask

    // Called at a negedge with inputs already set; compares every output
    // against the model, crosses one rising edge, returns at the next negedge.
    task automatic cycle();
        logic ev, er, cap;
        logic [31:0] e1, e2;
        #1;
        ev = m_have && (m_wait == 0);
        er = !flush && (!m_have || (ev && out_ready));
        e1 = m_have ? fwd_val(m_rs, m_src1) : m_src1;
        e2 = m_have ? fwd_val(m_rt, m_src2) : m_src2;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("alu_src1", alu_src1, e1);
        chk("alu_src2", alu_src2, e2);
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        chk("rd", 32'(rd_out), 32'(m_rd));
        chk("regwrite", 32'(regwrite_out), 32'(m_we));
        cap = in_valid && er;
        @(posedge clk);
        if (m_have && !cap) begin
            m_src1 = e1;
            m_src2 = e2;
        end
        if (flush) begin
            m_have = 0;
        end else if (cap) begin
            m_have = 1;
            m_src1 = src1; m_src2 = src2; m_ctrl = ctrl;
            m_rs = rs; m_rt = rt; m_rd = rd; m_we = regwrite;
            m_wait = (ctrl == C_MUL) ? MC - 1 : 0;
        end else if (ev && out_ready) begin
            m_have = 0;
        end else if (m_have && m_wait > 0) begin
            m_wait--;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        exmem_rd = 0; exmem_we = 0; exmem_data = 0;
        memwb_rd = 0; memwb_we = 0; memwb_data = 0;
        set_in(0, 4'b0000, 0, 0, 1, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_ctrl", 32'(alu_ctrl), 0);
        chk("reset_src1", alu_src1, 0);
        rst = 1'b0;
        cycle();

        // ADD latency 1
        set_in(1, C_ADD, 5, 7, 1, 0);
        cycle();
        in_valid = 0;
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_ctrl", 32'(alu_ctrl), 32'(C_ADD));
        chk("t1_src1", alu_src1, 5);
        chk("t1_src2", alu_src2, 7);
        cycle();

        // MUL held MC cycles; a following ADD waits
        set_in(1, C_MUL, 6, 7, 1, 0);
        cycle();
        set_in(1, C_ADD, 1, 2, 1, 0);
        for (int i = 0; i < MC - 1; i++) begin
            #1;
            chk("t2_busy_ready", 32'(in_ready), 0);
            chk("t2_busy_valid", 32'(out_valid), 0);
            cycle();
        end
        chk("t2_mul_valid", 32'(out_valid), 1);
        chk("t2_mul_ctrl", 32'(alu_ctrl), 32'(C_MUL));
        chk("t2_mul_src1", alu_src1, 6);
        cycle();
        chk("t2_add_ctrl", 32'(alu_ctrl), 32'(C_ADD));
        chk("t2_add_src2", alu_src2, 2);
        in_valid = 0;
        cycle();

        // Backpressure then release with a back-to-back accept
        set_in(1, C_SLT, 9, 3, 0, 0);
        cycle();
        set_in(1, C_ADD, 11, 12, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_stall_ready", 32'(in_ready), 0);
            chk("t3_stall_src1", alu_src1, 9);
            cycle();
        end
        out_ready = 1;
        #1;
        chk("t3_release_ready", 32'(in_ready), 1);
        cycle();
        chk("t3_next_src1", alu_src1, 11);
        in_valid = 0;
        cycle();

        // Flush during MUL_WAIT with an incoming instruction
        set_in(1, C_MUL, 2, 3, 1, 0);
        cycle();
        set_in(1, C_ADD, 8, 8, 1, 1);
        #1;
        chk("t4_flush_ready", 32'(in_ready), 0);
        cycle();
        set_in(0, C_ADD, 0, 0, 1, 0);
        for (int i = 0; i < MC + 1; i++) begin
            chk("t4_no_valid", 32'(out_valid), 0);
            cycle();
        end

`ifdef FWD_EN
        set_in(1, C_ADD, 32'h11, 32'h22, 0, 0);
        rs = 5'd3;
        cycle();
        in_valid = 0;
        exmem_rd = 3; exmem_we = 1; exmem_data = 32'hAA;
        memwb_rd = 3; memwb_we = 1; memwb_data = 32'hBB;
        #1;
        chk("t5_fwd_exmem", alu_src1, 32'hAA);
        cycle();
        out_ready = 1;
        exmem_we = 0; memwb_we = 0;
        cycle();
        set_in(1, C_ADD, 32'h33, 32'h44, 0, 0);
        rs = 5'd0;
        cycle();
        exmem_rd = 0; exmem_we = 1; exmem_data = 32'hAA;
        #1;
        chk("t5_no_fwd_r0", alu_src1, 32'h33);
        exmem_we = 0; out_ready = 1; in_valid = 0;
        cycle();
`endif

        // Reset in the middle of a MUL
        set_in(1, C_MUL, 4, 5, 1, 0);
        cycle();
        in_valid = 0;
        cycle();
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_src1", alu_src1, 0);
        chk("t6_rst_ctrl", 32'(alu_ctrl), 0);
        chk("t6_rst_rd", 32'(rd_out), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_in(1, C_ADD, 21, 22, 1, 0);
        cycle();
        in_valid = 0;
        chk("t6_add_valid", 32'(out_valid), 1);
        chk("t6_add_src1", alu_src1, 21);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] c;
            case ($urandom_range(0, 4))
                0: c = C_MUL;
                1: c = C_ADD;
                2: c = C_SLT;
                3: c = 4'b0110;
                default: c = 4'b0001;
            endcase
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            ctrl      = c;
            src1      = $urandom;
            src2      = $urandom;
            rs        = 5'($urandom_range(0, 3));
            rt        = 5'($urandom_range(0, 3));
            rd        = 5'($urandom_range(0, 31));
            regwrite  = 1'($urandom_range(0, 1));
            exmem_rd  = 5'($urandom_range(0, 3));
            exmem_we  = 1'($urandom_range(0, 1));
            exmem_data = $urandom;
            memwb_rd  = 5'($urandom_range(0, 3));
            memwb_we  = 1'($urandom_range(0, 1));
            memwb_data = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
